// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if
// Bundles the three channels seen by the Wishbone command master:
//   cmd_* : host command stream (valid/ready, we, adr, dat)
//   rsp_* : per-command response (valid/ready, dat, 2-bit status)
//   wb_*  : Wishbone classic bus towards the slave
// Modport master is the block itself; modport slave is its environment
// (host plus Wishbone slave).
interface wb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic [1:0]        rsp_status;

  logic                wb_cyc_o;
  logic                wb_stb_o;
  logic                wb_we_o;
  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_ack_i;
  logic                wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_status,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_status,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// Wishbone classic master that executes queued single read/write commands.
// Commands enter a DEPTH-deep FIFO, are issued one at a time, and each one
// returns exactly one response (read data + status: 00 ok, 01 bus error,
// 10 timeout). A transaction without ack/err for TIMEOUT cycles is aborted.
// Ports:
//   clk_125m, rst_n : clock, asynchronous active-low reset
//   bus             : wb_cmd_master_if.master (cmd_*, rsp_*, wb_* signals)
//   busy            : FIFO non-empty or a transaction/response outstanding
//   fifo_level      : number of commands currently queued
module wb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk_125m,
  input  logic                   rst_n,
  wb_cmd_master_if.master        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUS  = 2'b01;
  localparam logic [1:0] ST_RSP  = 2'b10;

  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_ERR = 2'b01;
  localparam logic [1:0] RSP_TMO = 2'b10;

  logic [ENT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  // One-cycle arming flag: IDLE spends one cycle arming before it issues,
  // which sets both the push-to-strobe latency and the post-response gap.
  logic             go_r;

  logic             push_s;
  logic             issue_s;
  logic             hit_s;
  logic             tmo_s;
  logic             hs_s;
  logic [LVL_W-1:0] level_next_s;
  logic [1:0]       state_next_s;
  logic [ENT_W-1:0] head_s;

  // Handshake decode, FIFO level and FSM next-state.
  always_comb begin
    push_s       = bus.cmd_valid & bus.cmd_ready;
    issue_s      = (state_r == ST_IDLE) & go_r & (fifo_level != LVL_ZERO);
    hit_s        = (state_r == ST_BUS) & (bus.wb_ack_i | bus.wb_err_i);
    tmo_s        = (state_r == ST_BUS) & ~(bus.wb_ack_i | bus.wb_err_i) & (cnt_r == CNT_LAST);
    hs_s         = (state_r == ST_RSP) & bus.rsp_valid & bus.rsp_ready;
    level_next_s = fifo_level + LVL_W'(push_s) - LVL_W'(issue_s);
    head_s       = mem_r[rd_ptr_r];
    case (state_r)
      ST_IDLE: begin
        if (issue_s) state_next_s = ST_BUS;
        else         state_next_s = ST_IDLE;
      end
      ST_BUS: begin
        if (hit_s | tmo_s) state_next_s = ST_RSP;
        else               state_next_s = ST_BUS;
      end
      ST_RSP: begin
        if (hs_s) state_next_s = ST_IDLE;
        else      state_next_s = ST_RSP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk_125m) begin
    if (push_s) mem_r[wr_ptr_r] <= {bus.cmd_we, bus.cmd_adr, bus.cmd_dat};
  end

  // FIFO pointers/level, status outputs, FSM and Wishbone/response registers.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r       <= {PTR_W{1'b0}};
      rd_ptr_r       <= {PTR_W{1'b0}};
      fifo_level     <= LVL_ZERO;
      bus.cmd_ready  <= 1'b0;
      busy           <= 1'b0;
      state_r        <= ST_IDLE;
      go_r           <= 1'b0;
      cnt_r          <= {CNT_W{1'b0}};
      bus.wb_cyc_o   <= 1'b0;
      bus.wb_stb_o   <= 1'b0;
      bus.wb_we_o    <= 1'b0;
      bus.wb_adr_o   <= {ADDR_W{1'b0}};
      bus.wb_dat_o   <= {DATA_W{1'b0}};
      bus.wb_sel_o   <= {(DATA_W/8){1'b1}};
      bus.rsp_valid  <= 1'b0;
      bus.rsp_dat    <= {DATA_W{1'b0}};
      bus.rsp_status <= RSP_OK;
    end else begin
      if (push_s)  wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (issue_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      fifo_level    <= level_next_s;
      // Ready looks at the post-edge level, so a pop never frees a slot
      // for a push in the same cycle.
      bus.cmd_ready <= (level_next_s != LVL_FULL);
      busy          <= (level_next_s != LVL_ZERO) | (state_next_s != ST_IDLE);
      bus.wb_sel_o  <= {(DATA_W/8){1'b1}};
      go_r          <= (state_r == ST_IDLE) & ~go_r & (fifo_level != LVL_ZERO);
      state_r       <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            {bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} <= head_s;
            bus.wb_cyc_o <= 1'b1;
            bus.wb_stb_o <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
          end
        end
        ST_BUS: begin
          if (hit_s | tmo_s) begin
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.rsp_valid <= 1'b1;
            // err wins over ack; ack/err both win over a same-cycle timeout
            if (bus.wb_err_i) begin
              bus.rsp_status <= RSP_ERR;
              bus.rsp_dat    <= {DATA_W{1'b0}};
            end else if (bus.wb_ack_i) begin
              bus.rsp_status <= RSP_OK;
              bus.rsp_dat    <= bus.wb_we_o ? {DATA_W{1'b0}} : bus.wb_dat_i;
            end else begin
              bus.rsp_status <= RSP_TMO;
              bus.rsp_dat    <= {DATA_W{1'b0}};
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        ST_RSP: begin
          if (hs_s) bus.rsp_valid <= 1'b0;
        end
        default: begin
          bus.wb_cyc_o  <= 1'b0;
          bus.wb_stb_o  <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master. A negedge process keeps a transaction-
// level model (command queue, expected-response queue, level/busy counters),
// plays an address-mapped Wishbone slave and compares the DUT every cycle.
// The stimulus block adds hand-computed literal expectations.
module tb_wb_cmd_master;
  localparam logic [31:0] TO_ADR  = 32'h0000_2000; // slave never answers
  localparam logic [31:0] ERR_ADR = 32'h0000_3000; // slave answers err+ack

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [2:0] fifo_level;
  int cyc_n = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit stray_en = 1'b0;

  wb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(255)) dut (
    .clk_125m  (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int delay_of(input logic [31:0] a);
    return (a == 32'h0000_1000) ? 3 : (a == TO_ADR) ? 255 : 1;
  endfunction

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h0000_1004) ? 32'hCAFE_F00D : (a ^ 32'hA5A5_0000);
  endfunction

  // Expected {status, data} for a command {we, adr, dat}.
  function automatic logic [33:0] rsp_of(input logic [64:0] c);
    if (c[63:32] == TO_ADR)  return {2'b10, 32'h0};
    if (c[63:32] == ERR_ADR) return {2'b01, 32'h0};
    if (c[64])               return {2'b00, 32'h0};
    return {2'b00, rd_fn(c[63:32])};
  endfunction

  // ---------------- model state (owned by the compare process) ----------
  logic [64:0] cmd_q[$];
  logic [33:0] rsp_q[$];
  logic [33:0] got_rsp[$];
  int          lens[$];
  int          iss_edges[$];
  int          hs_edges[$];
  logic [64:0] cur = '0;
  logic [64:0] pend_cmd = '0;
  int          mcount = 0;
  int          cur_len = 0;
  bit          inflight = 1'b0;
  bit          rsp_pend = 1'b0;
  bit          pend_push = 1'b0;
  bit          pend_hs = 1'b0;
  bit          prev_cyc = 1'b0;

  function automatic logic [33:0] rsp_at(input int i);
    return (i < got_rsp.size()) ? got_rsp[i] : 34'h3_FFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_q.delete(); rsp_q.delete();
      mcount = 0; inflight = 0; rsp_pend = 0; pend_push = 0; pend_hs = 0;
      prev_cyc = 0; cur_len = 0;
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = 32'h0;
    end else begin
      // events of the edge that just passed
      if (pend_push) begin cmd_q.push_back(pend_cmd); mcount++; end
      if (pend_hs) begin
        if (rsp_q.size() > 0) rsp_q.delete(0);
        rsp_pend = 0; inflight = 0; hs_edges.push_back(cyc_n);
      end
      if (bus.wb_cyc_o && !prev_cyc) begin
        check("issue_with_cmd_queued", 64'(cmd_q.size() != 0), 64'd1);
        if (cmd_q.size() > 0) begin
          cur = cmd_q.pop_front(); mcount--; inflight = 1; cur_len = 0;
          rsp_q.push_back(rsp_of(cur)); iss_edges.push_back(cyc_n);
        end
      end
      if (bus.wb_cyc_o) begin
        cur_len++;
        check("wb_stb", 64'(bus.wb_stb_o), 64'd1);
        check("wb_we",  64'(bus.wb_we_o),  64'(cur[64]));
        check("wb_adr", 64'(bus.wb_adr_o), 64'(cur[63:32]));
        check("wb_dat", 64'(bus.wb_dat_o), 64'(cur[31:0]));
      end else begin
        check("wb_stb_idle", 64'(bus.wb_stb_o), 64'd0);
      end
      if (!bus.wb_cyc_o && prev_cyc) begin
        check("cyc_len", 64'(cur_len), 64'(delay_of(cur[63:32])));
        lens.push_back(cur_len);
        rsp_pend = 1;
      end
      check("fifo_level", 64'(fifo_level), 64'(mcount));
      check("cmd_ready", 64'(bus.cmd_ready), 64'(mcount != 4));
      check("busy", 64'(busy), 64'(mcount != 0 || inflight));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_pend));
      check("wb_sel", 64'(bus.wb_sel_o), 64'h0F);
      if (bus.rsp_valid && rsp_q.size() > 0)
        check("rsp_fields", 64'({bus.rsp_status, bus.rsp_dat}), 64'(rsp_q[0]));
      // slave drive for the coming edge
      if (bus.wb_cyc_o && cur[63:32] != TO_ADR && cur_len == delay_of(cur[63:32])) begin
        bus.wb_ack_i = 1'b1; bus.wb_err_i = (cur[63:32] == ERR_ADR);
        bus.wb_dat_i = rd_fn(cur[63:32]);
      end else if (!bus.wb_cyc_o && stray_en) begin
        bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'h5555_AAAA;
      end else begin
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = 32'h0BAD_0BAD;
      end
      pend_push = bus.cmd_valid && (mcount != 4);
      pend_cmd  = {bus.cmd_we, bus.cmd_adr, bus.cmd_dat};
      pend_hs   = bus.rsp_valid && bus.rsp_ready && rsp_pend;
      if (pend_hs) got_rsp.push_back({bus.rsp_status, bus.rsp_dat});
      prev_cyc = bus.wb_cyc_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input int max, output bit ok, output int edge_n);
    bit acc;
    ok = 0; edge_n = -1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_dat = dat;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk); acc = bus.cmd_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1; edge_n = cyc_n; end
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clk); #1;
      if (!busy && !bus.rsp_valid) done = 1;
    end
    if (!done) begin n_chk++; $display("FAIL wait_idle: still busy after %0d cycles", max); end
  endtask

  task automatic reset_release();
    @(negedge clk); #1; rst_n = 1'b1;
    check("ready_before_edge", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin
    bit ok;
    int k, n_ok;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = 32'h0; bus.cmd_dat = 32'h0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk); #1;
    check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
    check("rst_sel", 64'(bus.wb_sel_o), 64'h0F);
    check("rst_adr", 64'(bus.wb_adr_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_status", 64'(bus.rsp_status), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd0);
    reset_release();

    // 1: write with ack after 3 cycles
    push(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4, ok, k);
    wait_idle(50);
    check("t1_latency", 64'((iss_edges.size() > 0 ? iss_edges[0] : -100) - k), 64'd2);
    check("t1_len", 64'(lens.size() > 0 ? lens[0] : -1), 64'd3);
    check("t1_rsp", 64'(rsp_at(0)), 64'({2'b00, 32'h0}));

    // 2: read
    push(1'b0, 32'h0000_1004, 32'h0, 4, ok, k);
    wait_idle(50);
    check("t2_rsp", 64'(rsp_at(1)), 64'({2'b00, 32'hCAFE_F00D}));

    // 3: timeout, then a queued write issues normally
    push(1'b0, TO_ADR, 32'h0, 4, ok, k);
    push(1'b1, 32'h0000_1008, 32'h1234_5678, 4, ok, k);
    wait_idle(600);
    check("t3_len", 64'(lens.size() > 2 ? lens[2] : -1), 64'd255);
    check("t3_rsp_tmo", 64'(rsp_at(2)), 64'({2'b10, 32'h0}));
    check("t3_rsp_next", 64'(rsp_at(3)), 64'({2'b00, 32'h0}));

    // 4: err together with ack on a read
    push(1'b0, ERR_ADR, 32'h0, 4, ok, k);
    wait_idle(50);
    check("t4_rsp", 64'(rsp_at(4)), 64'({2'b01, 32'h0}));

    // 5: back-pressure; stray ack/err while nothing is on the bus
    @(posedge clk); #1; bus.rsp_ready = 1'b0; stray_en = 1'b1;
    push(1'b0, 32'h0000_1100, 32'h0, 4, ok, k);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); #1; ok = bus.rsp_valid; end
    check("t5_first_rsp_waiting", 64'(ok), 64'd1);
    n_ok = 0;
    push(1'b1, 32'h0000_1104, 32'h1111_1111, 3, ok, k); n_ok += int'(ok);
    push(1'b0, 32'h0000_1108, 32'h0, 3, ok, k);         n_ok += int'(ok);
    push(1'b1, 32'h0000_110C, 32'h2222_2222, 3, ok, k); n_ok += int'(ok);
    push(1'b0, 32'h0000_1110, 32'h0, 3, ok, k);         n_ok += int'(ok);
    check("t5_accepted", 64'(n_ok), 64'd4);
    @(negedge clk); #1;
    check("t5_level_full", 64'(fifo_level), 64'd4);
    check("t5_ready_full", 64'(bus.cmd_ready), 64'd0);
    push(1'b1, 32'h0000_1114, 32'h3333_3333, 4, ok, k);
    check("t5_push_when_full", 64'(ok), 64'd0);
    stray_en = 1'b0; bus.rsp_ready = 1'b1;
    wait_idle(200);
    check("t5_rsp_count", 64'(got_rsp.size()), 64'd10);
    check("t5_rsp_first", 64'(rsp_at(5)), 64'({2'b00, 32'hA5A5_1100}));
    check("t5_rsp_last", 64'(rsp_at(9)), 64'({2'b00, 32'hA5A5_1110}));
    check("t5_gap", 64'((iss_edges.size() > 6 ? iss_edges[6] : -100) -
                        (hs_edges.size() > 5 ? hs_edges[5] : 0)), 64'd2);

    // 6: reset while a transaction hangs with two commands queued
    push(1'b0, TO_ADR, 32'h0, 4, ok, k);
    push(1'b0, 32'h0000_1200, 32'h0, 4, ok, k);
    push(1'b1, 32'h0000_1204, 32'h4444_4444, 4, ok, k);
    @(negedge clk); #1;
    check("t6_cyc_before", 64'(bus.wb_cyc_o), 64'd1);
    check("t6_level_before", 64'(fifo_level), 64'd2);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    check("t6_cyc", 64'(bus.wb_cyc_o), 64'd0);
    check("t6_stb", 64'(bus.wb_stb_o), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("t6_ready", 64'(bus.cmd_ready), 64'd0);
    repeat (3) @(posedge clk);
    reset_release();
    repeat (30) @(negedge clk);
    #1;
    check("t6_no_rsp", 64'(got_rsp.size()), 64'd10);
    check("t6_idle", 64'({busy, bus.wb_cyc_o, bus.rsp_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
Parametrised Wishbone classic master that executes a queue of single read/write commands on the NIC's Wishbone bus. Commands are buffered in a small FIFO and issued one at a time. Each command returns exactly one response carrying read data and a status code. The block adds a per-transaction timeout and bus-error reporting, so a hung slave cannot stall the host side. It is used in NIC bring-up and in the register-access path between the host interface and the WR NIC register file.

Parameters:
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width (multiple of 8)
DEPTH, 4, command FIFO depth (power of 2, >=2)
TIMEOUT, 255, max cycles cyc/stb held without ack/err before abort (>=1)

Ports:
clk_125m  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept command
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADDR_W  command address
cmd_dat  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_dat  out  DATA_W  read data (0 for writes and failed reads)
rsp_status  out  2  00 ok, 01 bus error, 10 timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_sel_o  out  DATA_W/8  byte selects, always all ones
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
busy  out  1  FIFO non-empty or FSM not IDLE
fifo_level  out  $clog2(DEPTH)+1  commands currently queued

Behaviour:
- Reset is asynchronous and active-low, with a single clock clk_125m.
- Reset values:
  - All outputs are 0, except wb_sel_o, which is all ones.
  - cmd_ready is 1 one cycle after rst_n deasserts (it is 0 while rst_n is low).
  - FIFO is emptied and the FSM returns to IDLE.
- FIFO:
  - cmd_ready = !full. A push happens on cmd_valid & cmd_ready.
  - When full, cmd_ready=0. No push is accepted even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - If the FIFO is non-empty, pop the head and register we/adr/dat onto the wb_*_o outputs.
  - Assert wb_cyc_o and wb_stb_o, clear the timeout counter, and go to BUS.
  - Latency: a command pushed into an empty FIFO at edge k has cyc/stb high after edge k+2.
- BUS:
  - cyc, stb, we, adr and dat are held stable. The timeout counter increments each cycle.
  - On wb_ack_i and not wb_err_i: rsp_dat = wb_dat_i for reads, 0 for writes; status=00.
  - On wb_err_i (with or without ack): status=01, rsp_dat=0.
  - When the counter reaches TIMEOUT with no ack/err: status=10, rsp_dat=0.
  - Ack/err arriving in the same cycle the counter reaches TIMEOUT takes precedence over the timeout.
  - On any of the three outcomes: deassert cyc/stb at that edge, set rsp_valid=1, go to RSP.
  - A timed-out transaction is not retried.
- RSP:
  - rsp_valid, rsp_dat and rsp_status are held until rsp_valid & rsp_ready.
  - On that handshake: clear rsp_valid and go to IDLE.
  - Minimum spacing between consecutive stb assertions is 2 idle cycles after the response handshake.
- While in BUS or RSP, the FIFO keeps accepting commands up to DEPTH.
- wb_ack_i and wb_err_i are ignored outside BUS.
- busy = (fifo_level != 0) | (state != IDLE).
- Reset mid-transaction:
  - cyc/stb drop asynchronously and queued commands are discarded.
  - No response is produced for the aborted or discarded commands.

Test Plan:
1. Reset, push write adr=0x1000 dat=0xDEADBEEF; slave acks 3 cycles after stb -> wb_we_o=1, wb_adr_o=0x1000, wb_dat_o=0xDEADBEEF held stable until ack; rsp_valid with status=00, rsp_dat=0; busy returns to 0.
2. Push read adr=0x1004; slave returns 0xCAFEF00D with ack -> rsp_dat=0xCAFEF00D, status=00; wb_we_o=0 during cycle.
3. Slave never acks, TIMEOUT=255 -> cyc/stb drop exactly 255 cycles after stb rises; status=10, rsp_dat=0; next queued command then issues normally.
4. Slave asserts err and ack together on a read -> status=01, rsp_dat=0.
5. Hold rsp_ready=0, push 5 commands with DEPTH=4 -> 4 accepted while the first sits in RSP, then cmd_ready=0 and fifo_level=4; release rsp_ready -> all commands complete in push order, with 4+1 total responses matching addresses.
6. Assert rst_n=0 mid-BUS with 2 commands queued -> wb_cyc_o/wb_stb_o=0 immediately, fifo_level=0, rsp_valid=0; no response after reset release.
